// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request in flight, naturally aligned memory
// accesses only, sign/zero-extended load results returned over a valid/ready port.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_misaligned,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_rw_size,
    output logic            mem_read,
    output logic            mem_write,
    output logic [31:0]     mem_write_data,
    input  logic [31:0]     mem_read_data
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lane_q, lane_d;

    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]      mem_size_q, mem_size_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_mis_q, rsp_mis_d;

    logic            accept;
    logic            req_mis;
    logic [31:0]     store_repl;
    logic [31:0]     lane_data;
    logic [31:0]     load_ext;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = req_addr[0];
            2'b10:   req_mis = |req_addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   store_repl = {4{req_wdata[7:0]}};
            2'b01:   store_repl = {2{req_wdata[15:0]}};
            default: store_repl = req_wdata;
        endcase
    end

    // Shift the addressed lane down to bit 0; halves are aligned so addr[0]=0 there.
    always_comb begin
        lane_data = mem_read_data >> {lane_q, 3'b000};
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{lane_data[7] & ~f3_q[2]}}, lane_data[7:0]};
            2'b01:   load_ext = {{16{lane_data[15] & ~f3_q[2]}}, lane_data[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_size_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_size_q  <= mem_size_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    lane_d  = req_addr[1:0];
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = req_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are launched on the accept edge so they cover exactly MEM_LAT cycles.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_size_d  = '0;
        mem_wdata_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_mis_d   = rsp_mis_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_mis) begin
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_read_d  = !req_we;
                        mem_write_d = req_we;
                        mem_addr_d  = req_addr;
                        mem_size_d  = req_funct3[1:0];
                        mem_wdata_d = req_we ? store_repl : '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                    mem_addr_d  = mem_addr_q;
                    mem_size_d  = mem_size_q;
                    mem_wdata_d = mem_wdata_q;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_mis_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : load_ext;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_mis_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_rw_size    = mem_size_q;
    assign mem_write_data = mem_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;

endmodule
